// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl
// Sequences the IF/ID pipeline register and owns the fetch PC.
// Each cycle it decides whether IF/ID loads the fetched instruction, holds,
// or loads a NOP bubble. It detects load-use hazards against ID, redirects
// fetch on taken branches and inserts a fixed refill gap, and halts fetch on
// EBREAK until resumed. It also decodes the immediate format of the fetched
// instruction.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ins_valid, ins       fetch result for the current PC
//   id_rs1n/id_rs2n      source register indices of the instruction in ID
//   id_uses_rs1/2        ID instruction actually reads rs1/rs2
//   ex_rdn, ex_memread   destination index / load flag of the instruction in EX
//   branch_taken/target  redirect request from EX
//   resume               single-cycle pulse that leaves HALT
//   pc                   registered fetch PC
//   ifid_en, ifid_bubble IF/ID load enable and NOP select
//   ex_bubble            ID/EX captures a bubble
//   immode               immediate format code for ins (0 on bubbles)
//   state                RUN=0, FLUSH=1, HALT=2
//   stall_cnt            saturating count of hazard / fetch-wait cycles
//   bubble_cnt           saturating count of cycles that loaded a NOP bubble
module ifid_hazard_ctrl #(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0,
    parameter int                  FlushCycles = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ins_valid,
    input  logic [31:0]         ins,
    input  logic [4:0]          id_rs1n,
    input  logic [4:0]          id_rs2n,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [4:0]          ex_rdn,
    input  logic                ex_memread,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] branch_target,
    input  logic                resume,
    output logic [WordSize-1:0] pc,
    output logic                ifid_en,
    output logic                ifid_bubble,
    output logic                ex_bubble,
    output logic [2:0]          immode,
    output logic [1:0]          state,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         bubble_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // The flush counter holds the number of FLUSH cycles still to run after
    // the current one, so it starts at FlushCycles-2 (the redirect cycle
    // itself is spent in RUN or HALT).
    localparam int                CntW       = (FlushCycles > 2) ? $clog2(FlushCycles) : 1;
    localparam bit                HasFlush   = (FlushCycles > 1);
    localparam logic [CntW-1:0]   FlushInit  = HasFlush ? CntW'(FlushCycles - 2) : '0;
    localparam logic [31:0]       Ebreak     = 32'h0010_0073;
    localparam logic [WordSize-1:0] PcStep   = WordSize'(32'd4);

    state_t              state_r;
    logic [WordSize-1:0] pc_r;
    logic [CntW-1:0]     cnt_r;
    logic [15:0]         stall_cnt_r;
    logic [15:0]         bubble_cnt_r;

    state_t              state_nxt_s;
    logic [WordSize-1:0] pc_nxt_s;
    logic [CntW-1:0]     cnt_nxt_s;
    logic                hz_s;
    logic                ifid_en_s;
    logic                ifid_bubble_s;
    logic                ex_bubble_s;
    logic                stall_inc_s;

    function automatic logic [2:0] imm_format(input logic [6:0] opcode);
        logic [2:0] code;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111: code = 3'd1;
            7'b0100011:                         code = 3'd2;
            7'b1100011:                         code = 3'd4;
            7'b0110111, 7'b0010111:             code = 3'd5;
            7'b1101111:                         code = 3'd6;
            default:                            code = 3'd0;
        endcase
        return code;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        logic [15:0] result;
        if (en && (value != 16'hFFFF)) begin
            result = value + 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        hz_s = ex_memread && (ex_rdn != 5'd0) &&
               ((id_uses_rs1 && (id_rs1n == ex_rdn)) ||
                (id_uses_rs2 && (id_rs2n == ex_rdn)));
    end

    // Next-state, next-PC and IF/ID control decision for this cycle.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        cnt_nxt_s     = cnt_r;
        ifid_en_s     = 1'b1;
        ifid_bubble_s = 1'b1;
        ex_bubble_s   = 1'b0;
        stall_inc_s   = 1'b0;
        case (state_r)
            RUN: begin
                if (branch_taken) begin
                    pc_nxt_s = branch_target;
                    if (HasFlush) begin
                        state_nxt_s = FLUSH;
                        cnt_nxt_s   = FlushInit;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (hz_s) begin
                    // IF/ID holds the consumer; ID/EX takes the bubble.
                    ifid_en_s     = 1'b0;
                    ifid_bubble_s = 1'b0;
                    ex_bubble_s   = 1'b1;
                    stall_inc_s   = 1'b1;
                end else if (!ins_valid) begin
                    stall_inc_s = 1'b1;
                end else if (ins == Ebreak) begin
                    // EBREAK itself enters IF/ID; fetch stops behind it.
                    ifid_bubble_s = 1'b0;
                    state_nxt_s   = HALT;
                end else begin
                    ifid_bubble_s = 1'b0;
                    pc_nxt_s      = pc_r + PcStep;
                end
            end
            FLUSH: begin
                if (ins_valid) begin
                    pc_nxt_s = pc_r + PcStep;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (cnt_r == '0) begin
                    state_nxt_s = RUN;
                end else begin
                    cnt_nxt_s = cnt_r - CntW'(1'b1);
                end
            end
            HALT: begin
                // A taken branch means the EBREAK was on the wrong path.
                if (branch_taken) begin
                    pc_nxt_s = branch_target;
                    if (HasFlush) begin
                        state_nxt_s = FLUSH;
                        cnt_nxt_s   = FlushInit;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (resume) begin
                    pc_nxt_s    = pc_r + PcStep;
                    state_nxt_s = RUN;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            default: begin
                // Unreachable encoding: bubble and fall back to RUN.
                state_nxt_s = RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Immediate format, suppressed whenever IF/ID is loading a bubble.
    always_comb begin
        if (ifid_bubble_s) begin
            immode = 3'd0;
        end else begin
            immode = imm_format(ins[6:0]);
        end
    end

    // State, PC, flush counter and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            pc_r         <= ResetVector;
            cnt_r        <= '0;
            stall_cnt_r  <= 16'd0;
            bubble_cnt_r <= 16'd0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            cnt_r        <= cnt_nxt_s;
            stall_cnt_r  <= sat_inc(stall_cnt_r, stall_inc_s);
            bubble_cnt_r <= sat_inc(bubble_cnt_r, ifid_en_s & ifid_bubble_s);
        end
    end

    assign pc          = pc_r;
    assign state       = state_r;
    assign stall_cnt   = stall_cnt_r;
    assign bubble_cnt  = bubble_cnt_r;
    assign ifid_en     = ifid_en_s;
    assign ifid_bubble = ifid_bubble_s;
    assign ex_bubble   = ex_bubble_s;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Testbench for ifid_hazard_ctrl: directed scenarios with literal expected
// values plus a randomized run checked against a rule-level reference model.
module tb_ifid_hazard_ctrl;

    localparam int          FC     = 2;
    localparam logic [31:0] ADDI   = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst;
    logic        ins_valid;
    logic [31:0] ins;
    logic [4:0]  id_rs1n, id_rs2n, ex_rdn;
    logic        id_uses_rs1, id_uses_rs2, ex_memread;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        resume;
    logic [31:0] pc;
    logic        ifid_en, ifid_bubble, ex_bubble;
    logic [2:0]  immode;
    logic [1:0]  state;
    logic [15:0] stall_cnt, bubble_cnt;

    int passed = 0;
    int total  = 0;

    // Reference model: mode 0=RUN 1=FLUSH 2=HALT, left = bubble cycles still owed.
    logic [31:0] m_pc,   n_pc;
    logic [1:0]  m_mode, n_mode;
    int          m_left, n_left;
    int          m_stall, n_stall;
    int          m_bub,   n_bub;
    logic        e_en, e_bub, e_exb;
    logic [2:0]  e_imm;

    ifid_hazard_ctrl #(
        .WordSize   (32),
        .ResetVector(32'h0),
        .FlushCycles(FC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ins_valid    (ins_valid),
        .ins          (ins),
        .id_rs1n      (id_rs1n),
        .id_rs2n      (id_rs2n),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rdn       (ex_rdn),
        .ex_memread   (ex_memread),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .resume       (resume),
        .pc           (pc),
        .ifid_en      (ifid_en),
        .ifid_bubble  (ifid_bubble),
        .ex_bubble    (ex_bubble),
        .immode       (immode),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] ref_imm(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 3'd1;
        if (op == 7'h23) return 3'd2;
        if (op == 7'h63) return 3'd4;
        if (op == 7'h37 || op == 7'h17) return 3'd5;
        if (op == 7'h6F) return 3'd6;
        return 3'd0;
    endfunction

    task automatic redirect();
        n_pc   = branch_target;
        n_left = FC - 1;
        n_mode = (n_left > 0) ? 2'd1 : 2'd0;
    endtask

    task automatic model_eval();
        bit hz;
        bit stall_hit;
        hz = ex_memread && (ex_rdn != 0) &&
             ((id_uses_rs1 && id_rs1n == ex_rdn) || (id_uses_rs2 && id_rs2n == ex_rdn));
        e_en = 1'b1; e_bub = 1'b1; e_exb = 1'b0; stall_hit = 1'b0;
        n_pc = m_pc; n_mode = m_mode; n_left = m_left;
        if (m_mode == 2'd0) begin
            if (branch_taken) redirect();
            else if (hz) begin e_en = 1'b0; e_bub = 1'b0; e_exb = 1'b1; stall_hit = 1'b1; end
            else if (!ins_valid) stall_hit = 1'b1;
            else if (ins == EBREAK) begin e_bub = 1'b0; n_mode = 2'd2; end
            else begin e_bub = 1'b0; n_pc = m_pc + 32'd4; end
        end else if (m_mode == 2'd1) begin
            if (ins_valid) n_pc = m_pc + 32'd4;
            n_left = m_left - 1;
            if (n_left == 0) n_mode = 2'd0;
        end else begin
            if (branch_taken) redirect();
            else if (resume) begin n_pc = m_pc + 32'd4; n_mode = 2'd0; end
        end
        e_imm   = e_bub ? 3'd0 : ref_imm(ins);
        n_stall = (m_stall + int'(stall_hit) > 65535) ? 65535 : m_stall + int'(stall_hit);
        n_bub   = (m_bub + int'(e_bub && e_en) > 65535) ? 65535 : m_bub + int'(e_bub && e_en);
        if (rst) begin
            n_pc = 32'h0; n_mode = 2'd0; n_left = 0; n_stall = 0; n_bub = 0;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic step();
        m_pc = n_pc; m_mode = n_mode; m_left = n_left; m_stall = n_stall; m_bub = n_bub;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ins_valid = 1'b1; ins = ADDI;
        id_rs1n = 5'd0; id_rs2n = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rdn = 5'd0; ex_memread = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; resume = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        settle();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        settle(); step();
        rst = 1'b0;
        settle();
        total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else passed++;
        total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
        total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else passed++;
        total++; if (bubble_cnt !== 16'd0) $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); else passed++;
        step();
    endtask

    task automatic test_addi();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            settle();
            total++; if (pc !== 32'(4 * i)) $display("FAIL addi_pc: got %h want %h", pc, 32'(4 * i)); else passed++;
            total++; if (ifid_bubble !== 1'b0) $display("FAIL addi_bubble: got %b want 0", ifid_bubble); else passed++;
            total++; if (immode !== 3'd1) $display("FAIL addi_immode: got %0d want 1", immode); else passed++;
            step();
        end
        settle();
        total++; if (pc !== 32'd16) $display("FAIL addi_pc_end: got %h want %h", pc, 32'd16); else passed++;
        total++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0)
            $display("FAIL addi_counters: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); else passed++;
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        settle(); step();
        settle(); step();
        ex_memread = 1'b1; ex_rdn = 5'd5; id_uses_rs1 = 1'b1; id_rs1n = 5'd5;
        settle();
        total++; if (ifid_en !== 1'b0) $display("FAIL lu_ifid_en: got %b want 0", ifid_en); else passed++;
        total++; if (ex_bubble !== 1'b1) $display("FAIL lu_ex_bubble: got %b want 1", ex_bubble); else passed++;
        step();
        ex_rdn = 5'd0; id_rs1n = 5'd0;
        settle();
        total++; if (pc !== 32'd8) $display("FAIL lu_pc_hold: got %h want %h", pc, 32'd8); else passed++;
        total++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall: got %0d want 1", stall_cnt); else passed++;
        total++; if (ifid_en !== 1'b1 || ex_bubble !== 1'b0)
            $display("FAIL lu_x0_nostall: got en=%b exb=%b want en=1 exb=0", ifid_en, ex_bubble); else passed++;
        step();
        drive_idle();
        settle();
        total++; if (pc !== 32'd12) $display("FAIL lu_x0_pc: got %h want %h", pc, 32'd12); else passed++;
        step();
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 8; i++) begin settle(); step(); end
        branch_taken = 1'b1; branch_target = 32'h100;
        settle();
        total++; if (pc !== 32'h20) $display("FAIL br_pc_pre: got %h want %h", pc, 32'h20); else passed++;
        total++; if (ifid_bubble !== 1'b1 || ifid_en !== 1'b1)
            $display("FAIL br_bubble: got en=%b bub=%b want 1/1", ifid_en, ifid_bubble); else passed++;
        step();
        branch_taken = 1'b0;
        settle();
        total++; if (pc !== 32'h100) $display("FAIL br_pc_target: got %h want %h", pc, 32'h100); else passed++;
        total++; if (state !== 2'd1) $display("FAIL br_state_flush: got %0d want 1", state); else passed++;
        step();
        settle();
        total++; if (pc !== 32'h104) $display("FAIL br_pc_after: got %h want %h", pc, 32'h104); else passed++;
        total++; if (state !== 2'd0) $display("FAIL br_state_run: got %0d want 0", state); else passed++;
        total++; if (bubble_cnt !== 16'd2) $display("FAIL br_bubble_cnt: got %0d want 2", bubble_cnt); else passed++;
        step();
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 16; i++) begin settle(); step(); end
        ins = EBREAK;
        settle();
        total++; if (ifid_bubble !== 1'b0 || immode !== 3'd0)
            $display("FAIL ebreak_load: got bub=%b imm=%0d want 0/0", ifid_bubble, immode); else passed++;
        step();
        ins = ADDI;
        for (int i = 0; i < 5; i++) begin
            settle();
            total++; if (state !== 2'd2 || pc !== 32'h40 || ifid_bubble !== 1'b1)
                $display("FAIL halt_hold: got st=%0d pc=%h bub=%b want 2/40/1", state, pc, ifid_bubble); else passed++;
            step();
        end
        resume = 1'b1;
        settle(); step();
        resume = 1'b0;
        settle();
        total++; if (pc !== 32'h44 || state !== 2'd0)
            $display("FAIL halt_resume: got pc=%h st=%0d want 44/0", pc, state); else passed++;
        total++; if (bubble_cnt !== 16'd6) $display("FAIL halt_bubbles: got %0d want 6", bubble_cnt); else passed++;
        ins = EBREAK;
        step();
        ins = ADDI; resume = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        settle(); step();
        drive_idle();
        settle();
        total++; if (pc !== 32'h80 || state !== 2'd1)
            $display("FAIL halt_branch_wins: got pc=%h st=%0d want 80/1", pc, state); else passed++;
        step();
    endtask

    task automatic test_fetch_wait();
        do_reset();
        ins_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin settle(); step(); end
        settle();
        total++; if (pc !== 32'h0) $display("FAIL wait_pc: got %h want 0", pc); else passed++;
        total++; if (stall_cnt !== 16'd3 || bubble_cnt !== 16'd3)
            $display("FAIL wait_counts: got %0d/%0d want 3/3", stall_cnt, bubble_cnt); else passed++;
        step();
        for (int i = 0; i < 70000; i++) begin settle(); step(); end
        settle();
        total++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_saturate: got %h want ffff", stall_cnt); else passed++;
        total++; if (bubble_cnt !== 16'hFFFF) $display("FAIL bubble_saturate: got %h want ffff", bubble_cnt); else passed++;
        step();
        drive_idle();
    endtask

    task automatic test_reset_abort();
        do_reset();
        branch_taken = 1'b1; branch_target = 32'h100;
        settle(); step();
        branch_taken = 1'b0; rst = 1'b1;
        settle(); step();
        rst = 1'b0;
        settle();
        total++; if (pc !== 32'h0 || state !== 2'd0 || bubble_cnt !== 16'd0)
            $display("FAIL rst_in_flush: got pc=%h st=%0d bc=%0d want 0/0/0", pc, state, bubble_cnt); else passed++;
        for (int k = 0; k < 2; k++) begin
            branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
            step();
            branch_taken = 1'b0; ins_valid = 1'b0;
            settle(); step();
            ins_valid = 1'b1;
            rst = (k == 0);
            settle();
            total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL top_pc: got %h want fffffffc", pc); else passed++;
            step();
            rst = 1'b0;
            settle();
            total++; if (pc !== 32'h0 || state !== 2'd0)
                $display("FAIL top_next_pc: got pc=%h st=%0d want 0/0", pc, state); else passed++;
            if (k == 0) begin
                total++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0)
                    $display("FAIL rst_top_counters: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); else passed++;
            end
        end
        step();
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ins_valid    = ($urandom_range(0, 9) < 8);
            ins          = {$urandom()} & 32'hFFFF_FF80 | {25'd0, ops[$urandom_range(0, 7)]};
            if ($urandom_range(0, 11) == 0) ins = EBREAK;
            ex_memread   = ($urandom_range(0, 3) == 0);
            ex_rdn       = 5'($urandom_range(0, 3));
            id_rs1n      = 5'($urandom_range(0, 3));
            id_rs2n      = 5'($urandom_range(0, 3));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 9) == 0);
            branch_target = {$urandom()} & 32'hFFFF_FFFC;
            resume       = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            settle();
            total++; if (pc !== m_pc) $display("FAIL rnd_pc: cyc %0d got %h want %h", i, pc, m_pc); else passed++;
            total++; if (state !== m_mode) $display("FAIL rnd_state: cyc %0d got %0d want %0d", i, state, m_mode); else passed++;
            total++; if ({ifid_en, ifid_bubble, ex_bubble} !== {e_en, e_bub, e_exb})
                $display("FAIL rnd_ctrl: cyc %0d got %b%b%b want %b%b%b", i, ifid_en, ifid_bubble, ex_bubble, e_en, e_bub, e_exb);
                else passed++;
            total++; if (immode !== e_imm) $display("FAIL rnd_immode: cyc %0d got %0d want %0d", i, immode, e_imm); else passed++;
            total++; if (stall_cnt !== 16'(m_stall) || bubble_cnt !== 16'(m_bub))
                $display("FAIL rnd_counters: cyc %0d got %0d/%0d want %0d/%0d", i, stall_cnt, bubble_cnt, m_stall, m_bub);
                else passed++;
            step();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        m_pc = 32'h0; m_mode = 2'd0; m_left = 0; m_stall = 0; m_bub = 0;
        drive_idle();
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_halt();
        test_fetch_wait();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
